piso_shift_reg: RTL and testbench

Parallel-in, serial-out shift register with a word-level valid/ready load port and a bit-level valid/ready serial port. It accepts a WIDTH-bit word, emits it one bit per accepted serial beat, and flags the final bit. It is the transmit end of the register library's serial path: it feeds any serial-in, parallel-out receiver built from the same flip-flop cells.

---
 rtl/reg_pkg.sv | 14 +
 rtl/piso_shift_reg.sv | 79 +++++++
 tb/tb_piso_shift_reg.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register library's serial path.
// Holds the state encoding and the counter-width helper.
package reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with word-level and bit-level valid/ready.
// A word is emitted one bit per accepted beat; the final bit is flagged with ser_last.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no word held; load_ready high, ser_out forced low by cleared sr
// ST_SHIFT | word in flight; cnt counts the bits remaining after ser_out
module piso_shift_reg
    import reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_shifted;

    assign ser_valid  = (state == ST_SHIFT);
    assign ser_last   = (state == ST_SHIFT) && (cnt == '0);
    assign busy       = ser_valid;
    // Ready during the last-bit consume lets a new word follow with no gap.
    assign load_ready = (state == ST_IDLE) || (ser_last && ser_ready);
    assign ser_out    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        sr    <= load_data;
                        cnt   <= CNT_MAX;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (cnt != '0) begin
                            sr  <= sr_shifted;
                            cnt <= cnt - 1'b1;
                        end else if (load_valid) begin
                            sr  <= load_data;
                            cnt <= CNT_MAX;
                        end else begin
                            sr    <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    sr    <= '0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: one MSB-first and one LSB-first instance
// share stimulus; expected bits are derived from the loaded words.
module tb_piso_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic m_load_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
    logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;

    int checks;
    int errors;

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .load_data  (load_data),
        .ser_out    (m_ser_out),
        .ser_valid  (m_ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (m_ser_last),
        .busy       (m_busy)
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .load_data  (load_data),
        .ser_out    (l_ser_out),
        .ser_valid  (l_ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (l_ser_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " m_valid"}, m_ser_valid, 1'b0);
        chk({tag, " m_last"},  m_ser_last,  1'b0);
        chk({tag, " m_out"},   m_ser_out,   1'b0);
        chk({tag, " m_busy"},  m_busy,      1'b0);
        chk({tag, " m_ready"}, m_load_ready, 1'b1);
        chk({tag, " l_valid"}, l_ser_valid, 1'b0);
        chk({tag, " l_out"},   l_ser_out,   1'b0);
        chk({tag, " l_ready"}, l_load_ready, 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entry point: 1 ns after a posedge with both instances idle.
    task automatic send_word(input string tag, input logic [7:0] d,
                             input int stall_at, input int stall_len);
        int cycles;
        cycles = 0;
        load_valid = 1'b1;
        load_data  = d;
        ser_ready  = 1'b1;
        #1;
        chk({tag, " load_ready"}, m_load_ready, 1'b1);
        next_cycle();
        load_valid = 1'b0;
        load_data  = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ser_ready  = 1'b0;
                    load_valid = 1'b1;
                    load_data  = 8'h00;
                    #1;
                    chk({tag, " stall m_out"},   m_ser_out,    d[7-i]);
                    chk({tag, " stall l_out"},   l_ser_out,    d[i]);
                    chk({tag, " stall m_valid"}, m_ser_valid,  1'b1);
                    chk({tag, " stall m_last"},  m_ser_last,   1'b0);
                    chk({tag, " stall m_ready"}, m_load_ready, 1'b0);
                    next_cycle();
                    cycles++;
                end
                load_valid = 1'b0;
            end
            ser_ready = 1'b1;
            #1;
            chk({tag, " m_valid"}, m_ser_valid,  1'b1);
            chk({tag, " m_busy"},  m_busy,       1'b1);
            chk({tag, " m_out"},   m_ser_out,    d[7-i]);
            chk({tag, " l_out"},   l_ser_out,    d[i]);
            chk({tag, " m_last"},  m_ser_last,   (i == 7));
            chk({tag, " l_last"},  l_ser_last,   (i == 7));
            chk({tag, " m_ready"}, m_load_ready, (i == 7));
            next_cycle();
            cycles++;
        end
        #1;
        chk({tag, " cycles"}, cycles, 8 + ((stall_at >= 0) ? stall_len : 0));
        chk_idle({tag, " end"});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        ser_ready  = 1'b0;
        #12;
        chk_idle("reset");

        next_cycle();
        rst_n     = 1'b1;
        ser_ready = 1'b1;
        next_cycle();
        next_cycle();
        chk_idle("idle");

        send_word("a5", 8'hA5, -1, 0);
        send_word("01", 8'h01, -1, 0);
        send_word("c3_bp", 8'hC3, 2, 3);

        // Back-to-back FF then 00 with the reload during the last-bit consume.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        ser_ready  = 1'b1;
        next_cycle();
        load_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) load_valid = 1'b0;
            #1;
            chk("b2b m_valid", m_ser_valid, 1'b1);
            chk("b2b m_out",   m_ser_out,   (i < 8));
            chk("b2b l_out",   l_ser_out,   (i < 8));
            chk("b2b m_last",  m_ser_last,  (i == 7) || (i == 15));
            chk("b2b l_last",  l_ser_last,  (i == 7) || (i == 15));
            next_cycle();
        end
        #1;
        chk_idle("b2b end");

        // Reset mid-word: three bits of F0 consumed, reset lands during bit 4.
        load_valid = 1'b1;
        load_data  = 8'hF0;
        ser_ready  = 1'b1;
        next_cycle();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("f0 m_out", m_ser_out, 1'b1);
            next_cycle();
        end
        #1;
        chk("f0 bit4 m_valid", m_ser_valid, 1'b1);
        chk("f0 bit4 m_out",   m_ser_out,   1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        next_cycle();
        chk_idle("midrst held");
        rst_n = 1'b1;
        next_cycle();
        chk_idle("midrst rel");
        send_word("0f", 8'h0F, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
